ooo_reg_scoreboard: RTL and testbench
=====================================

// Module: ooo_reg_scoreboard
// PURPOSE
//  Register busy/ownership table feeding the OoO hazard unit. Decode queries
//  rs1/rs2/rd here to drive rs1_busy, rs2_busy, rd_busy. A writeback-slot
//  reservation ring drives wb_port_conflict. Commit releases registers by
//  ROB tag; execute_commit_flush clears all speculative state.
// PARAMETERS
//  NUM_REGS      32  architectural integer registers (x0 never busy)
//  TAG_W         4   ROB index width
//  WB_RES_DEPTH  8   writeback reservation horizon (cycles); legal fu_lat 1..WB_RES_DEPTH-1
// PORTS
//  CLK             in   1      clock
//  RST             in   1      asynchronous reset, active-high
//  flush           in   1      execute_commit_flush; clears table and ring
//  stall           in   1      stall_de; dispatch not accepted this cycle
//  dispatch        in   1      decode presents a valid instruction
//  wen             in   1      instruction writes rd
//  rs1, rs2, rd    in   5      decode register indices
//  tag             in   TAG_W  ROB index allocated to the dispatching instruction
//  fu_lat          in   3      fixed FU latency; 0 = variable (div, load/store), no reservation
//  commit_valid    in   1      ROB retiring an instruction that wrote a register
//  commit_rd       in   5      retiring destination
//  commit_tag      in   TAG_W  retiring ROB index
//  rs1_busy        out  1      rs1 has an in-flight producer
//  rs2_busy        out  1      rs2 has an in-flight producer
//  rd_busy         out  1      rd has an in-flight producer (WAW)
//  rs1_tag         out  TAG_W  producer tag of rs1 (valid when rs1_busy)
//  rs2_tag         out  TAG_W  producer tag of rs2 (valid when rs2_busy)
//  wb_port_conflict out 1      requested writeback slot already reserved
// BEHAVIOUR
//  - Reset (async, RST=1): every busy bit 0, every tag 0, ring 0. All outputs 0.
//  - Lookups are combinational on the current table, with zero latency.
//    Index 0 always reads busy=0 and tag=0.
//  - Commit bypass: if commit_valid && commit_rd==rsX && commit_tag==table tag,
//    then rsX_busy=0 in the same cycle. rd_busy uses the same rule.
//  - accept = dispatch & ~stall & ~flush & ~wb_port_conflict.
//    When accept & wen & rd!=0, on the next edge busy[rd]<=1 and tag[rd]<=tag.
//  - Commit release happens on the edge only if busy[commit_rd] && tag matches.
//    A stale tag (reg re-dispatched) is ignored.
//  - Same-cycle accept to rd and commit of the same rd: set wins, new tag stored.
//  - Ring res[WB_RES_DEPTH-1:1]: res[k]=1 means the wb port is taken k cycles ahead.
//  - wb_port_conflict = dispatch & wen & (fu_lat!=0) & res[fu_lat]. It is combinational.
//  - Each edge the ring shifts down by one (res>>1) regardless of stall.
//    If accept & wen & fu_lat!=0, bit (fu_lat-1) is also set.
//  - Flush beats both dispatch and commit on that edge: table and ring are cleared.
//  - fu_lat >= WB_RES_DEPTH is illegal and asserted. Dispatch without wen
//    reserves nothing and sets no busy bit.
// STRUCTURE
//  - rv32i_types_pkg gets: sb_entry_t {logic busy; logic [TAG_W-1:0] tag;}
//    and localparam WB_RES_DEPTH_DEFAULT.
//  - Sub-module wb_slot_reserve holds the ring, the shift/set logic and the
//    conflict compare.
//  - The top level holds the NUM_REGS x sb_entry_t array, the lookup muxes and
//    the bypass logic.
// TESTING
//  - Reset: RST=1 mid-run with busy[5]=1 -> all outputs 0 immediately; rs1=5 reads busy=0.
//  - RAW: dispatch rd=5 tag=3 wen; next cycle rs1=5 -> rs1_busy=1, rs1_tag=3.
//    Then commit rd=5 tag=3 -> rs1_busy=0 in that same cycle.
//  - WAW/stale: dispatch rd=7 tag=1, then rd=7 tag=2. Commit rd=7 tag=1
//    -> rd_busy stays 1, tag 2. Commit tag=2 -> clear.
//  - Same-cycle: commit rd=9 tag=4 while accepting rd=9 tag=6 -> busy[9]=1, tag 6.
//  - WB ring: accept fu_lat=3. Next cycle fu_lat=2 -> conflict=1, no busy set.
//    fu_lat=3 -> conflict=0. Stall high -> ring still drains.
//  - Flush with 4 busy regs and ring bits set -> next cycle all busy=0, conflict=0.
//    x0 dispatch -> never busy.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
// Shared types for the OoO register scoreboard.
//   TAG_W                 ROB index width
//   REG_IDX_W             architectural register index width
//   WB_RES_DEPTH_DEFAULT  default writeback reservation horizon (cycles)
//   sb_entry_t            one scoreboard row: busy flag + producer ROB tag
//   commit_hits()         true when a retiring instruction releases the entry
package rv32i_types_pkg;

  localparam int TAG_W                = 4;
  localparam int REG_IDX_W            = 5;
  localparam int WB_RES_DEPTH_DEFAULT = 8;

  typedef struct packed {
    logic             busy;
    logic [TAG_W-1:0] tag;
  } sb_entry_t;

  // A commit releases a row only when it names the row's current producer;
  // an older tag for a re-dispatched register must not clear it.
  function automatic logic commit_hits(input sb_entry_t            ent,
                                       input logic [REG_IDX_W-1:0] idx,
                                       input logic                 cvalid,
                                       input logic [REG_IDX_W-1:0] crd,
                                       input logic [TAG_W-1:0]     ctag);
    return cvalid && (crd == idx) && ent.busy && (ctag == ent.tag);
  endfunction

endpackage

// File: rtl/wb_slot_reserve.sv
// Writeback-port reservation ring.
//   clk, rst          clock, asynchronous active-high reset
//   flush             clears every reservation
//   stall, dispatch   decode handshake; a reservation is made only on accept
//   wen, fu_lat       requesting instruction writes a register with this latency
//   wb_port_conflict  the slot fu_lat cycles ahead is already taken
// res_q[k]=1 means the writeback port is taken k cycles from now.
module wb_slot_reserve
  import rv32i_types_pkg::*;
#(
  parameter int WB_RES_DEPTH = WB_RES_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       stall,
  input  logic       dispatch,
  input  logic       wen,
  input  logic [2:0] fu_lat,
  output logic       wb_port_conflict
);

  logic [WB_RES_DEPTH-1:1] res_q, res_d;
  logic                    slot_taken;
  logic                    reserve;

  always_comb begin
    slot_taken = 1'b0;
    for (int k = 1; k < WB_RES_DEPTH; k++) begin
      if (int'(fu_lat) == k) slot_taken = res_q[k];
    end
  end

  assign wb_port_conflict = dispatch & wen & (fu_lat != 3'd0) & slot_taken;
  assign reserve = dispatch & ~stall & ~flush & ~wb_port_conflict & wen & (fu_lat != 3'd0);

  // The ring drains every cycle even under stall. A new reservation lands at
  // fu_lat-1 because by the next cycle its writeback is one cycle closer;
  // fu_lat=1 writes back next cycle and never needs a slot in the ring.
  always_comb begin
    res_d = '0;
    for (int k = 1; k < WB_RES_DEPTH - 1; k++) begin
      res_d[k] = res_q[k+1];
      if (reserve && int'(fu_lat) == k + 1) res_d[k] = 1'b1;
    end
    if (flush) res_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments only; all next-state
  // math lives in always_comb with blocking assignments and a default first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) res_q <= '0;
    else     res_q <= res_d;
  end

  a_fu_lat_legal : assert property (@(posedge clk) disable iff (rst)
    !(dispatch && wen && int'(fu_lat) >= WB_RES_DEPTH));

endmodule

// File: rtl/ooo_reg_scoreboard.sv
// Register busy/ownership table for the OoO hazard unit.
//   clk, rst            clock, asynchronous active-high reset
//   flush               clears table and writeback ring
//   stall, dispatch     decode handshake
//   wen, rs1, rs2, rd   decode register usage
//   tag, fu_lat         ROB tag and fixed FU latency of the dispatching instr
//   commit_*            ROB retirement of a register-writing instruction
//   rs1/rs2/rd_busy     in-flight producer present (commit bypassed)
//   rs1/rs2_tag         producer ROB tags
//   wb_port_conflict    requested writeback slot already reserved
module ooo_reg_scoreboard
  import rv32i_types_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int WB_RES_DEPTH = WB_RES_DEPTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 stall,
  input  logic                 dispatch,
  input  logic                 wen,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic [REG_IDX_W-1:0] rd,
  input  logic [TAG_W-1:0]     tag,
  input  logic [2:0]           fu_lat,
  input  logic                 commit_valid,
  input  logic [REG_IDX_W-1:0] commit_rd,
  input  logic [TAG_W-1:0]     commit_tag,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rd_busy,
  output logic [TAG_W-1:0]     rs1_tag,
  output logic [TAG_W-1:0]     rs2_tag,
  output logic                 wb_port_conflict
);

  sb_entry_t table_q [NUM_REGS];
  sb_entry_t table_d [NUM_REGS];
  sb_entry_t rs1_ent, rs2_ent, rd_ent;
  logic      accept;

  wb_slot_reserve #(.WB_RES_DEPTH(WB_RES_DEPTH)) u_wb_slot_reserve (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .stall            (stall),
    .dispatch         (dispatch),
    .wen              (wen),
    .fu_lat           (fu_lat),
    .wb_port_conflict (wb_port_conflict)
  );

  assign accept = dispatch & ~stall & ~flush & ~wb_port_conflict;

  // Lookups: x0 reads as an empty row regardless of table contents.
  always_comb begin
    rs1_ent = (rs1 == '0) ? '0 : table_q[rs1];
    rs2_ent = (rs2 == '0) ? '0 : table_q[rs2];
    rd_ent  = (rd  == '0) ? '0 : table_q[rd];
  end

  // Same-cycle commit bypass lets decode see the release without a bubble.
  assign rs1_busy = rs1_ent.busy & ~commit_hits(rs1_ent, rs1, commit_valid, commit_rd, commit_tag);
  assign rs2_busy = rs2_ent.busy & ~commit_hits(rs2_ent, rs2, commit_valid, commit_rd, commit_tag);
  assign rd_busy  = rd_ent.busy  & ~commit_hits(rd_ent,  rd,  commit_valid, commit_rd, commit_tag);
  assign rs1_tag  = rs1_ent.tag;
  assign rs2_tag  = rs2_ent.tag;

  // Priority, lowest to highest: release, new dispatch (set wins over a
  // same-register commit), flush.
  always_comb begin
    table_d = table_q;
    if (commit_hits(table_q[commit_rd], commit_rd, commit_valid, commit_rd, commit_tag))
      table_d[commit_rd].busy = 1'b0;
    if (accept && wen && rd != '0) begin
      table_d[rd].busy = 1'b1;
      table_d[rd].tag  = tag;
    end
    if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) table_d[i] = '0;
    end
  end

  // NOTE: this table is real flops that must read empty straight out of
  // reset, so every row is reset; it is not a RAM and cannot be left unset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) table_q[i] <= '0;
    end else begin
      table_q <= table_d;
    end
  end

endmodule

// File: tb/tb_ooo_reg_scoreboard.sv
// Directed bench for ooo_reg_scoreboard. Inputs change on the falling edge;
// combinational outputs are sampled 1 ns later, well before the rising edge.
module tb_ooo_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush, stall, dispatch, wen;
  logic [4:0] rs1, rs2, rd;
  logic [3:0] tag;
  logic [2:0] fu_lat;
  logic       commit_valid;
  logic [4:0] commit_rd;
  logic [3:0] commit_tag;
  logic       rs1_busy, rs2_busy, rd_busy;
  logic [3:0] rs1_tag, rs2_tag;
  logic       wb_port_conflict;

  int n_checks = 0;
  int n_fail   = 0;

  ooo_reg_scoreboard dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .stall            (stall),
    .dispatch         (dispatch),
    .wen              (wen),
    .rs1              (rs1),
    .rs2              (rs2),
    .rd               (rd),
    .tag              (tag),
    .fu_lat           (fu_lat),
    .commit_valid     (commit_valid),
    .commit_rd        (commit_rd),
    .commit_tag       (commit_tag),
    .rs1_busy         (rs1_busy),
    .rs2_busy         (rs2_busy),
    .rd_busy          (rd_busy),
    .rs1_tag          (rs1_tag),
    .rs2_tag          (rs2_tag),
    .wb_port_conflict (wb_port_conflict)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic idle();
    flush = 0; stall = 0; dispatch = 0; wen = 0;
    rs1 = 0; rs2 = 0; rd = 0; tag = 0; fu_lat = 0;
    commit_valid = 0; commit_rd = 0; commit_tag = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic disp(input logic [4:0] r, input logic [3:0] t, input logic [2:0] lat);
    idle();
    dispatch = 1; wen = 1; rd = r; tag = t; fu_lat = lat;
  endtask

  task automatic test_reset();
    // Still in power-on reset.
    idle();
    rs1 = 5; rs2 = 5; rd = 5; dispatch = 1; wen = 1; stall = 1; fu_lat = 1;
    #1;
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL por_rs1_busy: got %0b want 0", rs1_busy); end
    n_checks++; if (rs1_tag !== 4'd0) begin n_fail++; $display("FAIL por_rs1_tag: got %0d want 0", rs1_tag); end
    n_checks++; if (wb_port_conflict !== 1'b0) begin n_fail++; $display("FAIL por_conflict: got %0b want 0", wb_port_conflict); end
    idle();
    @(negedge clk); rst = 0;
    step();
    // Mid-run reset: busy[5]=1 and a ring slot 3 ahead.
    disp(5, 3, 4);
    step();
    idle(); rs1 = 5; dispatch = 1; wen = 1; stall = 1; fu_lat = 3;
    #1;
    n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL pre_rst_busy: got %0b want 1", rs1_busy); end
    n_checks++; if (wb_port_conflict !== 1'b1) begin n_fail++; $display("FAIL pre_rst_conflict: got %0b want 1", wb_port_conflict); end
    #2 rst = 1;
    #1;
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy: got %0b want 0", rs1_busy); end
    n_checks++; if (rs1_tag !== 4'd0) begin n_fail++; $display("FAIL async_rst_tag: got %0d want 0", rs1_tag); end
    n_checks++; if (wb_port_conflict !== 1'b0) begin n_fail++; $display("FAIL async_rst_conflict: got %0b want 0", wb_port_conflict); end
    idle();
    @(negedge clk); rst = 0;
    step();
  endtask

  task automatic test_raw();
    disp(5, 3, 0);
    step();
    idle(); rs1 = 5; rs2 = 5;
    #1;
    n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL raw_rs1_busy: got %0b want 1", rs1_busy); end
    n_checks++; if (rs1_tag !== 4'd3) begin n_fail++; $display("FAIL raw_rs1_tag: got %0d want 3", rs1_tag); end
    n_checks++; if (rs2_tag !== 4'd3) begin n_fail++; $display("FAIL raw_rs2_tag: got %0d want 3", rs2_tag); end
    commit_valid = 1; commit_rd = 5; commit_tag = 3;
    #1;
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL raw_bypass_rs1: got %0b want 0", rs1_busy); end
    n_checks++; if (rs2_busy !== 1'b0) begin n_fail++; $display("FAIL raw_bypass_rs2: got %0b want 0", rs2_busy); end
    step();
    commit_valid = 0;
    #1;
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL raw_released: got %0b want 0", rs1_busy); end
  endtask

  task automatic test_waw_stale();
    disp(7, 1, 0);
    step();
    disp(7, 2, 0);
    #1;
    n_checks++; if (rd_busy !== 1'b1) begin n_fail++; $display("FAIL waw_rd_busy: got %0b want 1", rd_busy); end
    step();
    idle(); rd = 7; rs1 = 7; commit_valid = 1; commit_rd = 7; commit_tag = 1;
    #1;
    n_checks++; if (rd_busy !== 1'b1) begin n_fail++; $display("FAIL stale_bypass: got %0b want 1", rd_busy); end
    step();
    commit_valid = 0;
    #1;
    n_checks++; if (rd_busy !== 1'b1) begin n_fail++; $display("FAIL stale_kept: got %0b want 1", rd_busy); end
    n_checks++; if (rs1_tag !== 4'd2) begin n_fail++; $display("FAIL stale_tag: got %0d want 2", rs1_tag); end
    commit_valid = 1; commit_tag = 2;
    #1;
    n_checks++; if (rd_busy !== 1'b0) begin n_fail++; $display("FAIL waw_bypass: got %0b want 0", rd_busy); end
    step();
    commit_valid = 0;
    #1;
    n_checks++; if (rd_busy !== 1'b0) begin n_fail++; $display("FAIL waw_cleared: got %0b want 0", rd_busy); end
  endtask

  task automatic test_same_cycle();
    disp(9, 4, 0);
    step();
    disp(9, 6, 0);
    commit_valid = 1; commit_rd = 9; commit_tag = 4;
    step();
    idle(); rs1 = 9;
    #1;
    n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL same_cycle_busy: got %0b want 1", rs1_busy); end
    n_checks++; if (rs1_tag !== 4'd6) begin n_fail++; $display("FAIL same_cycle_tag: got %0d want 6", rs1_tag); end
    commit_valid = 1; commit_rd = 9; commit_tag = 6;
    step();
    idle();
  endtask

  task automatic test_wb_ring();
    disp(10, 5, 3);
    #1;
    n_checks++; if (wb_port_conflict !== 1'b0) begin n_fail++; $display("FAIL ring_first: got %0b want 0", wb_port_conflict); end
    step();
    // Ring now {2}.
    disp(11, 6, 2);
    #1;
    n_checks++; if (wb_port_conflict !== 1'b1) begin n_fail++; $display("FAIL ring_lat2: got %0b want 1", wb_port_conflict); end
    fu_lat = 3;
    #1;
    n_checks++; if (wb_port_conflict !== 1'b0) begin n_fail++; $display("FAIL ring_lat3: got %0b want 0", wb_port_conflict); end
    step();
    // Ring now {1,2}; rd 11 accepted with lat 3.
    idle(); rs1 = 11;
    #1;
    n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL ring_accepted: got %0b want 1", rs1_busy); end
    disp(12, 7, 1); stall = 1;
    #1;
    n_checks++; if (wb_port_conflict !== 1'b1) begin n_fail++; $display("FAIL ring_stall_lat1: got %0b want 1", wb_port_conflict); end
    step();
    // Drained under stall to {1}; an unstalled conflicting dispatch is refused.
    disp(12, 7, 1);
    #1;
    n_checks++; if (wb_port_conflict !== 1'b1) begin n_fail++; $display("FAIL ring_drain1: got %0b want 1", wb_port_conflict); end
    fu_lat = 2; stall = 1;
    #1;
    n_checks++; if (wb_port_conflict !== 1'b0) begin n_fail++; $display("FAIL ring_drain2: got %0b want 0", wb_port_conflict); end
    fu_lat = 1; stall = 0;
    step();
    idle(); rs1 = 12; dispatch = 1; wen = 1; stall = 1; fu_lat = 1;
    #1;
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL ring_conflict_no_busy: got %0b want 0", rs1_busy); end
    n_checks++; if (wb_port_conflict !== 1'b0) begin n_fail++; $display("FAIL ring_empty: got %0b want 0", wb_port_conflict); end
    // Dispatch without wen reserves nothing and sets nothing.
    idle(); dispatch = 1; rd = 13; tag = 8; fu_lat = 3;
    step();
    idle(); rs1 = 13; dispatch = 1; wen = 1; stall = 1; fu_lat = 2;
    #1;
    n_checks++; if (wb_port_conflict !== 1'b0) begin n_fail++; $display("FAIL nowen_reserve: got %0b want 0", wb_port_conflict); end
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL nowen_busy: got %0b want 0", rs1_busy); end
    idle(); commit_valid = 1; commit_rd = 10; commit_tag = 5;
    step();
    commit_rd = 11; commit_tag = 6;
    step();
    idle();
  endtask

  task automatic test_flush();
    disp(1, 1, 5); step();
    disp(2, 2, 6); step();
    disp(3, 3, 7); step();
    disp(4, 4, 0); step();
    // Ring now {1,3,5}.
    idle(); rs1 = 1; dispatch = 1; wen = 1; stall = 1; fu_lat = 3;
    #1;
    n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL preflush_busy: got %0b want 1", rs1_busy); end
    n_checks++; if (wb_port_conflict !== 1'b1) begin n_fail++; $display("FAIL preflush_conflict: got %0b want 1", wb_port_conflict); end
    disp(20, 7, 2); flush = 1;
    commit_valid = 1; commit_rd = 2; commit_tag = 2;
    step();
    idle(); rs1 = 1; rs2 = 2; rd = 3;
    #1;
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL flush_r1: got %0b want 0", rs1_busy); end
    n_checks++; if (rs2_busy !== 1'b0) begin n_fail++; $display("FAIL flush_r2: got %0b want 0", rs2_busy); end
    n_checks++; if (rd_busy !== 1'b0) begin n_fail++; $display("FAIL flush_r3: got %0b want 0", rd_busy); end
    rs1 = 4; rs2 = 20;
    #1;
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL flush_r4: got %0b want 0", rs1_busy); end
    n_checks++; if (rs2_busy !== 1'b0) begin n_fail++; $display("FAIL flush_dispatch_blocked: got %0b want 0", rs2_busy); end
    dispatch = 1; wen = 1; stall = 1;
    for (int l = 1; l < 8; l++) begin
      fu_lat = 3'(l);
      #0.5;
      n_checks++; if (wb_port_conflict !== 1'b0) begin n_fail++; $display("FAIL flush_ring lat=%0d: got %0b want 0", l, wb_port_conflict); end
    end
    idle();
  endtask

  task automatic test_x0();
    disp(0, 9, 0);
    step();
    idle(); rs1 = 0; rs2 = 0; rd = 0;
    #1;
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL x0_rs1_busy: got %0b want 0", rs1_busy); end
    n_checks++; if (rs1_tag !== 4'd0) begin n_fail++; $display("FAIL x0_rs1_tag: got %0d want 0", rs1_tag); end
    n_checks++; if (rd_busy !== 1'b0) begin n_fail++; $display("FAIL x0_rd_busy: got %0b want 0", rd_busy); end
  endtask

  initial begin
    rst = 1;
    idle();
    @(negedge clk);
    test_reset();
    test_raw();
    test_waw_stale();
    test_same_cycle();
    test_wb_ring();
    test_flush();
    test_x0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
